result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
- REQ-001: Parameter DEPTH, default 8, result-word capacity; SHALL be a power of two, minimum 2.
- REQ-002: Parameter DATA_W, default 64, result-word width; SHALL match peripheral output_reg width.
- REQ-003: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-004: n_rst  input  1  reset; one clock, reset is synchronous and active-high (port name kept per codebase convention; asserted = 1).
- REQ-005: data_ready  input  1  one-cycle strobe from peripheral marking output_reg valid.
- REQ-006: output_reg  input  DATA_W  result word from peripheral, sampled when data_ready=1.
- REQ-007: clear  input  1  soft flush from AHB subordinate.
- REQ-008: rd_req  input  1  AHB-side pop request, one word per asserted cycle.
- REQ-009: err_clr  input  1  clears sticky error flags.
- REQ-010: rd_data  output  DATA_W  popped word.
- REQ-011: rd_valid  output  1  rd_data holds a newly popped word this cycle.
- REQ-012: empty, full  output  1 each  occupancy status.
- REQ-013: overflow_err, underflow_err  output  1 each  sticky error flags.

Function
- REQ-014: Storage SHALL be a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping DEPTH-1 -> 0, plus a count of log2(DEPTH)+1 bits.
- REQ-015: data_ready=1 with count<DEPTH SHALL write output_reg at wr_ptr and advance wr_ptr.
- REQ-016: rd_req=1 with count>0 SHALL load mem[rd_ptr] into rd_data and advance rd_ptr; rd_valid SHALL be 1 in the following cycle only.
- REQ-017: Read latency SHALL be exactly one cycle from rd_req to rd_valid/rd_data.
- REQ-018: rd_data SHALL hold its last value when rd_valid=0.
- REQ-019: Write and read in the same cycle SHALL both complete and leave count unchanged, including when full or when count=1.
- REQ-020: Write when full without a same-cycle read SHALL drop the word, leave all pointers unchanged, and set overflow_err.
- REQ-021: rd_req when empty SHALL set underflow_err; rd_valid SHALL stay 0 and rd_data unchanged. A same-cycle write SHALL still be stored and SHALL NOT be bypassed.
- REQ-022: empty SHALL equal (count==0); full SHALL equal (count==DEPTH); both are registered-state decodes with no combinational path from inputs.
- REQ-023: clear SHALL zero the pointers and count and deassert rd_valid next cycle; same-cycle data_ready and rd_req SHALL be ignored; error flags SHALL be preserved.
- REQ-024: err_clr SHALL zero both error flags; a same-cycle error event SHALL win, leaving that flag set.

Reset
- REQ-025: n_rst=1 at a clock edge SHALL set pointers, count, rd_data, rd_valid, overflow_err and underflow_err to 0, and empty to 1, full to 0; storage contents need not reset.
- REQ-026: Reset mid-operation SHALL discard all buffered words; reset SHALL have priority over clear, writes and reads.

Configuration
- REQ-027: Macro RESULT_BUFFER_COUNT_EN defined SHALL add output port result_count (log2(DEPTH)+1 bits) equal to the registered count, reset 0; undefined, the port SHALL be absent and behaviour otherwise identical.

Structure
- REQ-028: Package result_pkg SHALL hold RESULT_DATA_W=64, RESULT_DEPTH=8 and typedefs result_word_t and result_ptr_t; parameter defaults SHALL reference them.
- REQ-029: Storage SHALL be sub-module result_mem (1 write port, 1 registered read port, no reset); pointer, count and error logic SHALL stay in result_buffer.

Verification
- REQ-030: Reset, then 3 data_ready strobes with words 0x11, 0x22, 0x33, then rd_req x3 -> rd_valid on cycles 1-3 after the first rd_req, rd_data 0x11, 0x22, 0x33; empty=1 at end.
- REQ-031: Write 9 words 0x1..0x9 into an empty buffer -> full=1 after the 8th, overflow_err=1 after the 9th, subsequent reads return 0x1..0x8.
- REQ-032: When full, data_ready with 0xAA plus rd_req in the same cycle -> count stays 8, no overflow, 0xAA read last after 7 more pops.
- REQ-033: rd_req when empty -> underflow_err=1, rd_valid=0; err_clr -> flag 0; err_clr in the same cycle as a new underflow -> flag stays 1.
- REQ-034: Write 12 words, reading 1 per write once count=4 (pointer wrap) -> FIFO order preserved; then clear -> empty=1 and errors unchanged; n_rst mid-stream -> all outputs at reset values next cycle.
- REQ-035: With RESULT_BUFFER_COUNT_EN defined, result_count tracks 0 -> 3 -> 8 -> 0 across the REQ-030/031 sequences.

Source files
------------

// File: rtl/result_pkg.sv
// Shared widths and types for the result buffer: default word width, depth and pointer types.
package result_pkg;

    localparam int RESULT_DATA_W = 64;
    localparam int RESULT_DEPTH  = 8;
    localparam int RESULT_PTR_W  = $clog2(RESULT_DEPTH);

    typedef logic [RESULT_DATA_W-1:0] result_word_t;
    typedef logic [RESULT_PTR_W-1:0]  result_ptr_t;
    typedef logic [RESULT_PTR_W:0]    result_count_t;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/result_mem.sv
// Dual-port storage array for result_buffer: one write port and one registered read port, no reset.
module result_mem
    import result_pkg::*;
#(
    parameter int DATA_W = RESULT_DATA_W,
    parameter int DEPTH  = RESULT_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: a read and write to the same slot return the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/result_buffer.sv
// Circular result FIFO between a peripheral and the AHB read side, with sticky error flags.
// Optional macro RESULT_BUFFER_COUNT_EN exposes the occupancy count as port result_count.
module result_buffer
    import result_pkg::*;
#(
    parameter int DEPTH  = RESULT_DEPTH,
    parameter int DATA_W = RESULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     data_ready,
    input  logic [DATA_W-1:0]        output_reg,
    input  logic                     clear,
    input  logic                     rd_req,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow_err,
`ifdef RESULT_BUFFER_COUNT_EN
    output logic                     underflow_err,
    output logic [$clog2(DEPTH):0]   result_count
`else
    output logic                     underflow_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("result_buffer: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_nxt;
    logic              wr_en;
    logic              rd_en;
    logic              ovf_evt;
    logic              udf_evt;
    logic              rd_zero;
    logic [DATA_W-1:0] mem_q;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // A read frees a slot in the same cycle, so a write at full is accepted alongside one.
    assign rd_en   = rd_req && !clear && !empty;
    assign wr_en   = data_ready && !clear && (!full || rd_en);
    assign ovf_evt = data_ready && !clear && full && !rd_req;
    assign udf_evt = rd_req && !clear && empty;

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_valid      <= 1'b0;
            rd_zero       <= 1'b1;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
            rd_valid <= rd_en;
            if (rd_en) rd_zero <= 1'b0;
            // A new error event outranks a same-cycle clear request.
            if (ovf_evt)      overflow_err <= 1'b1;
            else if (err_clr) overflow_err <= 1'b0;
            if (udf_evt)      underflow_err <= 1'b1;
            else if (err_clr) underflow_err <= 1'b0;
        end
    end

    result_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (output_reg),
        .rd_en   (rd_en && !n_rst),
        .rd_addr (rd_ptr),
        .rd_q    (mem_q)
    );

    // The unreset read register is masked until the first pop after reset.
    assign rd_data = rd_zero ? '0 : mem_q;

`ifdef RESULT_BUFFER_COUNT_EN
    assign result_count = count;
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Directed self-checking bench for result_buffer covering ordering, full/empty edges, errors, clear and reset.
module tb_result_buffer;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          data_ready;
    logic [DW-1:0] output_reg;
    logic          clear;
    logic          rd_req;
    logic          err_clr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          overflow_err;
    logic          underflow_err;
`ifdef RESULT_BUFFER_COUNT_EN
    logic [3:0]    result_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    result_buffer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .data_ready    (data_ready),
        .output_reg    (output_reg),
        .clear         (clear),
        .rd_req        (rd_req),
        .err_clr       (err_clr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .full          (full),
        .overflow_err  (overflow_err),
`ifdef RESULT_BUFFER_COUNT_EN
        .underflow_err (underflow_err),
        .result_count  (result_count)
`else
        .underflow_err (underflow_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        n_rst = 1'b0; data_ready = 1'b0; output_reg = '0;
        clear = 1'b0; rd_req = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle(); n_rst = 1'b1; tick(); tick(); idle();
        total_cnt++;
        if ({empty, full, rd_valid, overflow_err, underflow_err} !== 5'b10000)
            $display("FAIL reset_flags got=%b want=10000", {empty, full, rd_valid, overflow_err, underflow_err});
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== 64'h0) $display("FAIL reset_rd_data got=%h want=0", rd_data);
        else pass_cnt++;
`ifdef RESULT_BUFFER_COUNT_EN
        total_cnt++;
        if (result_count !== 4'd0) $display("FAIL reset_count got=%0d want=0", result_count);
        else pass_cnt++;
`endif
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp [3];
        exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            idle(); data_ready = 1'b1; output_reg = exp[i]; tick();
        end
        idle();
`ifdef RESULT_BUFFER_COUNT_EN
        total_cnt++;
        if (result_count !== 4'd3) $display("FAIL basic_count got=%0d want=3", result_count);
        else pass_cnt++;
`endif
        for (int i = 0; i < 3; i++) begin
            idle(); rd_req = 1'b1; tick();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== exp[i])
                $display("FAIL basic_pop%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, exp[i]);
            else pass_cnt++;
        end
        idle(); tick();
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h33 || empty !== 1'b1)
            $display("FAIL basic_hold got=%b/%h/%b want=0/33/1", rd_valid, rd_data, empty);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            idle(); data_ready = 1'b1; output_reg = DW'(i); tick();
            if (i == 8) begin
                total_cnt++;
                if (full !== 1'b1 || overflow_err !== 1'b0)
                    $display("FAIL ovf_full8 got=%b/%b want=1/0", full, overflow_err);
                else pass_cnt++;
`ifdef RESULT_BUFFER_COUNT_EN
                total_cnt++;
                if (result_count !== 4'd8) $display("FAIL ovf_count got=%0d want=8", result_count);
                else pass_cnt++;
`endif
            end
        end
        idle();
        total_cnt++;
        if (overflow_err !== 1'b1 || full !== 1'b1)
            $display("FAIL ovf_flag got=%b/%b want=1/1", overflow_err, full);
        else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            idle(); rd_req = 1'b1; tick();
            total_cnt++;
            if (rd_valid !== 1'b1 || rd_data !== DW'(i))
                $display("FAIL ovf_pop%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, DW'(i));
            else pass_cnt++;
        end
        idle();
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL ovf_empty got=%b want=1", empty);
        else pass_cnt++;
`ifdef RESULT_BUFFER_COUNT_EN
        total_cnt++;
        if (result_count !== 4'd0) $display("FAIL ovf_count0 got=%0d want=0", result_count);
        else pass_cnt++;
`endif
        err_clr = 1'b1; tick(); idle();
        total_cnt++;
        if (overflow_err !== 1'b0) $display("FAIL ovf_clr got=%b want=0", overflow_err);
        else pass_cnt++;
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= 8; i++) begin
            idle(); data_ready = 1'b1; output_reg = DW'(i); tick();
        end
        idle(); data_ready = 1'b1; output_reg = 64'hAA; rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h1 || full !== 1'b1 || overflow_err !== 1'b0)
            $display("FAIL fullrw_same got=%b/%h/%b/%b want=1/1/1/0", rd_valid, rd_data, full, overflow_err);
        else pass_cnt++;
        for (int i = 2; i <= 9; i++) begin
            idle(); rd_req = 1'b1; tick();
            total_cnt++;
            if (rd_data !== ((i == 9) ? 64'hAA : DW'(i)))
                $display("FAIL fullrw_pop%0d got=%h want=%h", i, rd_data, (i == 9) ? 64'hAA : DW'(i));
            else pass_cnt++;
        end
        idle();
        total_cnt++;
        if (empty !== 1'b1) $display("FAIL fullrw_empty got=%b want=1", empty);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        idle(); rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (underflow_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 64'hAA)
            $display("FAIL udf_set got=%b/%b/%h want=1/0/aa", underflow_err, rd_valid, rd_data);
        else pass_cnt++;
        err_clr = 1'b1; tick(); idle();
        total_cnt++;
        if (underflow_err !== 1'b0) $display("FAIL udf_clr got=%b want=0", underflow_err);
        else pass_cnt++;
        err_clr = 1'b1; rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (underflow_err !== 1'b1) $display("FAIL udf_clr_race got=%b want=1", underflow_err);
        else pass_cnt++;
        // Read on empty with a same-cycle write: the word is stored, not forwarded.
        data_ready = 1'b1; output_reg = 64'h5A; rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (rd_valid !== 1'b0 || empty !== 1'b0 || rd_data !== 64'hAA)
            $display("FAIL udf_nobypass got=%b/%b/%h want=0/0/aa", rd_valid, empty, rd_data);
        else pass_cnt++;
        rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h5A || empty !== 1'b1)
            $display("FAIL udf_stored got=%b/%h/%b want=1/5a/1", rd_valid, rd_data, empty);
        else pass_cnt++;
    endtask

    task automatic test_wrap_clear_reset();
        int rd_idx = 0;
        for (int i = 0; i < 12; i++) begin
            idle(); data_ready = 1'b1; output_reg = 64'h100 + DW'(i);
            rd_req = (i >= 4);
            tick();
            if (i >= 4) begin
                total_cnt++;
                if (rd_valid !== 1'b1 || rd_data !== 64'h100 + DW'(rd_idx))
                    $display("FAIL wrap_pop%0d got=%b/%h want=1/%h", rd_idx, rd_valid, rd_data, 64'h100 + DW'(rd_idx));
                else pass_cnt++;
                rd_idx++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            idle(); rd_req = 1'b1; tick();
            total_cnt++;
            if (rd_data !== 64'h100 + DW'(rd_idx))
                $display("FAIL wrap_tail%0d got=%h want=%h", rd_idx, rd_data, 64'h100 + DW'(rd_idx));
            else pass_cnt++;
            rd_idx++;
        end
        idle(); clear = 1'b1; data_ready = 1'b1; output_reg = 64'hFF; rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || underflow_err !== 1'b1 || overflow_err !== 1'b0)
            $display("FAIL clear_state got=%b/%b/%b/%b want=1/0/1/0", empty, rd_valid, underflow_err, overflow_err);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            idle(); data_ready = 1'b1; output_reg = 64'h200 + DW'(i); tick();
        end
        idle(); n_rst = 1'b1; clear = 1'b1; data_ready = 1'b1; output_reg = 64'hEE; rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if ({empty, full, rd_valid, overflow_err, underflow_err} !== 5'b10000 || rd_data !== 64'h0)
            $display("FAIL midreset got=%b/%h want=10000/0", {empty, full, rd_valid, overflow_err, underflow_err}, rd_data);
        else pass_cnt++;
        rd_req = 1'b1; tick(); idle();
        total_cnt++;
        if (rd_valid !== 1'b0 || underflow_err !== 1'b1)
            $display("FAIL midreset_discard got=%b/%b want=0/1", rd_valid, underflow_err);
        else pass_cnt++;
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_wrap_clear_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
